processor_mem: RTL

Memory responder for the accumulator processor: answers its instruction-fetch port (12-bit words) and data-memory port (32-bit words) from internal arrays. Contains a byte-serial loader that fills both memories from a host while holding the processor in reset, then releases it. Sits beside the processor at top level; `cpu_rst` drives the processor's `rst`.

---
 rtl/processor_mem_pkg.sv | 16 +
 rtl/mem_loader.sv | 95 +++++++++
 rtl/processor_mem.sv | 86 ++++++++
 3 files changed

// File: rtl/processor_mem_pkg.sv
// Shared widths, loader state encoding and the memory-mapped output address.
package processor_mem_pkg;
  localparam int AW = 8;
  localparam int IW = 12;
  localparam int DW = 32;

  localparam logic [AW-1:0] MMIO_ADDR = 8'hFF;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_ILO,
    ST_IHI,
    ST_DB,
    ST_RUN
  } ld_state_t;
endpackage

// File: rtl/mem_loader.sv
// Byte-serial loader FSM: fills imem then dmem, holds the processor in reset meanwhile.
// Write ports fire combinationally on the accepting edge; ld_ready is high only in load states.
module mem_loader
  import processor_mem_pkg::*;
#(
  parameter int IWORDS = 256,
  parameter int DWORDS = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_start,
  input  logic          go,
  input  logic          ld_valid,
  input  logic [7:0]    ld_byte,
  output logic          ld_ready,
  output logic          cpu_rst,
  output logic          run,
  output logic          iwe,
  output logic [AW-1:0] ia,
  output logic [IW-1:0] id,
  output logic          dwe,
  output logic [AW-1:0] da,
  output logic [DW-1:0] dd
);
  localparam logic [AW-1:0] ILAST = AW'(IWORDS - 1);
  localparam logic [AW-1:0] DLAST = AW'(DWORDS - 1);

  ld_state_t     state;
  ld_state_t     state_nxt;
  logic [AW-1:0] ptr;
  logic [7:0]    lo;
  logic [1:0]    bcnt;
  logic [23:0]   dbuf;
  logic          take;

  // A restart or reset in the same cycle wins over the byte on the bus.
  assign take = ld_valid & ld_ready & ~ld_start & ~rst;

  always_comb begin
    state_nxt = state;
    if (rst) begin
      state_nxt = ST_HOLD;
    end else if (ld_start) begin
      state_nxt = ST_ILO;
    end else begin
      case (state)
        ST_HOLD: if (go) state_nxt = ST_RUN;
        ST_ILO:  if (take) state_nxt = ST_IHI;
        ST_IHI:  if (take) state_nxt = (ptr == ILAST) ? ST_DB : ST_ILO;
        ST_DB:   if (take && bcnt == 2'd3 && ptr == DLAST) state_nxt = ST_RUN;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_HOLD;
      cpu_rst  <= 1'b1;
      ld_ready <= 1'b0;
      ptr      <= '0;
      bcnt     <= '0;
    end else begin
      state    <= state_nxt;
      cpu_rst  <= (state_nxt != ST_RUN);
      ld_ready <= (state_nxt inside {ST_ILO, ST_IHI, ST_DB});
      if (ld_start) begin
        ptr  <= '0;
        bcnt <= '0;
      end else if (take) begin
        case (state)
          ST_ILO: lo <= ld_byte;
          ST_IHI: begin
            ptr  <= (ptr == ILAST) ? '0 : ptr + 8'd1;
            bcnt <= '0;
          end
          ST_DB: begin
            dbuf <= {ld_byte, dbuf[23:8]};
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) ptr <= ptr + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign run = (state == ST_RUN);
  assign iwe = take & (state == ST_IHI);
  assign ia  = ptr;
  assign id  = {ld_byte[3:0], lo};
  assign dwe = take & (state == ST_DB) & (bcnt == 2'd3);
  assign da  = ptr;
  assign dd  = {ld_byte, dbuf};
endmodule

// File: rtl/processor_mem.sv
// Instruction/data memory responder with host loader; PMEM_MMIO_EN adds the 0xFF output register.
// Reads are combinational; loader takes one byte per cycle, ld_ready is low outside load states.
module processor_mem
  import processor_mem_pkg::*;
#(
  parameter int IWORDS = 256,
  parameter int DWORDS = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] instr_addr,
  output logic [IW-1:0] instr,
  input  logic          mem_wr,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data_out,
  output logic [DW-1:0] mem_data_in,
  input  logic          ld_start,
  input  logic          go,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [7:0]    ld_byte,
  output logic          cpu_rst
`ifdef PMEM_MMIO_EN
  ,
  output logic [DW-1:0] io_out,
  output logic          io_strobe
`endif
);
  localparam int DEPTH = 1 << AW;

  logic [IW-1:0] imem [0:DEPTH-1];
  logic [DW-1:0] dmem [0:DEPTH-1];

  logic          run;
  logic          iwe;
  logic [AW-1:0] ia;
  logic [IW-1:0] id;
  logic          dwe;
  logic [AW-1:0] da;
  logic [DW-1:0] dd;
  logic          cpu_wr;

  mem_loader #(
    .IWORDS (IWORDS),
    .DWORDS (DWORDS)
  ) u_loader (
    .clk      (clk),
    .rst      (rst),
    .ld_start (ld_start),
    .go       (go),
    .ld_valid (ld_valid),
    .ld_byte  (ld_byte),
    .ld_ready (ld_ready),
    .cpu_rst  (cpu_rst),
    .run      (run),
    .iwe      (iwe),
    .ia       (ia),
    .id       (id),
    .dwe      (dwe),
    .da       (da),
    .dd       (dd)
  );

  assign cpu_wr      = mem_wr & run & ~rst;
  assign instr       = imem[instr_addr];
  assign mem_data_in = dmem[mem_addr];

  // Arrays carry no reset: loaded contents survive rst and a reload.
  always_ff @(posedge clk) begin
    if (iwe) imem[ia] <= id;
    if (dwe) dmem[da] <= dd;
    else if (cpu_wr) dmem[mem_addr] <= mem_data_out;
  end

`ifdef PMEM_MMIO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      io_out    <= '0;
      io_strobe <= 1'b0;
    end else begin
      io_strobe <= cpu_wr && (mem_addr == MMIO_ADDR);
      if (cpu_wr && mem_addr == MMIO_ADDR) io_out <= mem_data_out;
    end
  end
`endif
endmodule
